// File: rtl/song_sel_pkg.sv
// Shared definitions for the song-select front panel: FSM states, event codes
// and the one-hot ROM select encoder.
package song_sel_pkg;

   localparam int IDX_W     = 2;
   localparam int MAX_SONGS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      GAP   = 2'd3
   } sel_state_t;

   typedef enum logic [2:0] {
      EV_NONE = 3'd0,
      EV_PLAY = 3'd1,
      EV_NEXT = 3'd2,
      EV_PREV = 3'd3,
      EV_DONE = 3'd4
   } sel_event_t;

   function automatic logic [MAX_SONGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces one raw button; emits a single-cycle pulse when
// the debounced level rises.
module btn_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic btn_raw,
   output logic press
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             stable_reg;
   logic             press_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         stable_reg <= 1'b0;
         press_reg  <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
         press_reg <= 1'b0;
         // Any sample agreeing with the stable level restarts the qualification window.
         if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            press_reg  <= sync2_reg;
            cnt_reg    <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/song_select_ctrl.sv
// Front-panel song sequencer: debounced play/next/prev, song_done auto-advance
// and a silent gap between songs so the player restarts cleanly.
module song_select_ctrl
   import song_sel_pkg::*;
#(
   parameter int DEB_CYCLES = 1_000_000,
   parameter int GAP_CYCLES = 5_000_000,
   parameter int NUM_SONGS  = 3,
   parameter int AUTO_NEXT  = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 btn_play,
   input  logic                 btn_next,
   input  logic                 btn_prev,
   input  logic                 song_done,
   output logic                 start,
   output logic [NUM_SONGS-1:0] en,
   output logic [1:0]           song_idx,
   output logic [1:0]           state_o
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SONGS - 1);

   logic [2:0]           btn_raw;
   logic [2:0]           btn_press;
   sel_event_t           ev;

   sel_state_t           state_reg, state_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
   logic [NUM_SONGS-1:0] en_reg, en_next;
   logic                 start_reg;

   logic [IDX_W-1:0]     idx_inc;
   logic [IDX_W-1:0]     idx_dec;
   logic [IDX_W-1:0]     idx_step;
   logic                 is_step;

   assign btn_raw = {btn_prev, btn_next, btn_play};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_deb
         btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .CLK     (CLK),
            .RST     (RST),
            .btn_raw (btn_raw[gi]),
            .press   (btn_press[gi])
         );
      end
   endgenerate

   // Only the highest-priority event of a cycle is acted on; the rest are dropped.
   always_comb begin
      ev = EV_NONE;
      if (btn_press[0])      ev = EV_PLAY;
      else if (btn_press[1]) ev = EV_NEXT;
      else if (btn_press[2]) ev = EV_PREV;
      else if (song_done)    ev = EV_DONE;
   end

   assign idx_inc  = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
   assign idx_dec  = (idx_reg == '0) ? IDX_LAST : idx_reg - 1'b1;
   assign is_step  = (ev == EV_NEXT) || (ev == EV_PREV);
   assign idx_step = (ev == EV_NEXT) ? idx_inc : idx_dec;

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      gap_cnt_next = gap_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (ev == EV_PLAY)  state_next = PLAY;
            else if (is_step)   idx_next   = idx_step;
         end
         PLAY: begin
            if (ev == EV_PLAY) begin
               state_next = PAUSE;
            end else if (is_step) begin
               idx_next     = idx_step;
               state_next   = GAP;
               gap_cnt_next = '0;
            end else if (ev == EV_DONE) begin
               if (AUTO_NEXT != 0) begin
                  idx_next     = idx_inc;
                  state_next   = GAP;
                  gap_cnt_next = '0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         PAUSE: begin
            if (ev == EV_PLAY) begin
               state_next = PLAY;
            end else if (is_step) begin
               idx_next   = idx_step;
               state_next = IDLE;
            end
         end
         GAP: begin
            // Button events win over gap expiry in the same cycle.
            if (ev == EV_PLAY) begin
               state_next = IDLE;
            end else if (is_step) begin
               idx_next     = idx_step;
               gap_cnt_next = '0;
            end else if (gap_cnt_reg == GAP_LAST) begin
               state_next = PLAY;
            end else begin
               gap_cnt_next = gap_cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign en_next = NUM_SONGS'(idx_onehot(idx_next));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         gap_cnt_reg <= '0;
         en_reg      <= NUM_SONGS'(1);
         start_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         gap_cnt_reg <= gap_cnt_next;
         en_reg      <= en_next;
         start_reg   <= (state_next == PLAY);
      end
   end

   assign start    = start_reg;
   assign en       = en_reg;
   assign song_idx = idx_reg;
   assign state_o  = state_reg;

endmodule
